// File: rtl/mcp_pkg.sv
// Shared types and frame constants for the MCP3008 SPI scanner.
package mcp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_DONE
  } mcp_state_e;

  localparam int unsigned MCP_FRAME_EDGES       = 17;
  localparam int unsigned MCP_FIRST_DATA_EDGE   = 8;
  localparam int unsigned MCP_CMD_BITS          = 5;
  localparam int unsigned MCP_FRAME_HALFPERIODS = 38;

  // Command bit k as seen on DIN: start, SGL, D2, D1, D0, then zeros.
  function automatic logic mcp_cmd_bit(input logic [2:0] ch, input logic [4:0] k);
    logic b;
    case (k)
      5'd0, 5'd1: b = 1'b1;
      5'd2:       b = ch[2];
      5'd3:       b = ch[1];
      5'd4:       b = ch[0];
      default:    b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mcp_spi_frame.sv
// One MCP3008 single-ended conversion frame (SETUP, 17 SCLK periods, HOLD, GAP).
module mcp_spi_frame
  import mcp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [2:0] i_ch,
  input  logic       i_miso,
  output logic       o_cs_n,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_raw_valid,
  output logic [9:0] o_raw,
  output logic       o_end_c
);

  localparam int unsigned DW = 8;
  localparam int unsigned EW = 5;
  // Half-periods left for the CS-high gap after SETUP, 17 SCLK periods and HOLD.
  localparam int unsigned GAP_HALVES = MCP_FRAME_HALFPERIODS - 2 * MCP_FRAME_EDGES - 2;

  mcp_state_e    r_state;
  logic [DW-1:0] r_div;
  logic [EW-1:0] r_edge;
  logic [9:0]    r_shift;
  logic          w_tick;
  logic [EW-1:0] w_edge_nxt;

  assign w_tick     = (r_div == DW'(CLK_DIV - 1));
  assign w_edge_nxt = r_edge + EW'(1);
  assign o_end_c    = (r_state == S_GAP) && w_tick && (r_edge == EW'(GAP_HALVES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_edge      <= '0;
      r_shift     <= '0;
      o_cs_n      <= 1'b1;
      o_sclk      <= 1'b0;
      o_mosi      <= 1'b0;
      o_raw       <= '0;
      o_raw_valid <= 1'b0;
    end else begin
      o_raw_valid <= 1'b0;
      if (r_state == S_IDLE || w_tick) r_div <= '0;
      else                             r_div <= r_div + DW'(1);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_SETUP;
            r_edge  <= '0;
            o_cs_n  <= 1'b0;
            o_mosi  <= mcp_cmd_bit(i_ch, 5'd0);
          end
        end
        S_SETUP: begin
          if (w_tick) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_tick) begin
            if (!o_sclk) begin
              o_sclk <= 1'b1;
              r_edge <= w_edge_nxt;
              if (w_edge_nxt >= EW'(MCP_FIRST_DATA_EDGE)) r_shift <= {r_shift[8:0], i_miso};
            end else begin
              // Falling edge after rise r_edge presents command bit r_edge.
              o_sclk <= 1'b0;
              o_mosi <= mcp_cmd_bit(i_ch, r_edge);
              if (r_edge == EW'(MCP_FRAME_EDGES)) begin
                r_state     <= S_HOLD;
                o_raw       <= r_shift;
                o_raw_valid <= 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_state <= S_GAP;
            r_edge  <= '0;
            o_cs_n  <= 1'b1;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_edge == EW'(GAP_HALVES - 1)) begin
              if (i_start) begin
                r_state <= S_SETUP;
                r_edge  <= '0;
                o_cs_n  <= 1'b0;
                o_mosi  <= mcp_cmd_bit(i_ch, 5'd0);
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_edge <= w_edge_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mcp3008_scanner.sv
// Scans MCP3008 channels 0..NUM_CH-1 and publishes all 8-bit results as one snapshot.
module mcp3008_scanner
  import mcp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned NUM_CH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic                spi_miso,
  output logic                spi_mosi,
  output logic                spi_sclk,
  output logic                spi_cs_n,
  output logic                busy,
  output logic                sample_valid,
  output logic [NUM_CH*8-1:0] ch_data,
  output logic [9:0]          last_raw
);

  localparam int unsigned CW = 3;

  // S_SETUP here means "frame sequence in flight"; the frame engine owns the sub-phases.
  mcp_state_e    r_state;
  logic [CW-1:0] r_ch;
  logic [7:0]    r_shadow [NUM_CH];
  logic          w_accept;
  logic          w_step;
  logic          w_last_ch;
  logic          w_frame_end;
  logic          w_raw_valid;

  assign w_last_ch = (r_ch == CW'(NUM_CH - 1));
  assign w_accept  = (r_state == S_IDLE) && ena && start;
  assign w_step    = (r_state == S_SETUP) && w_frame_end && !w_last_ch;

  mcp_spi_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_accept || w_step),
    .i_ch        (r_ch),
    .i_miso      (spi_miso),
    .o_cs_n      (spi_cs_n),
    .o_sclk      (spi_sclk),
    .o_mosi      (spi_mosi),
    .o_raw_valid (w_raw_valid),
    .o_raw       (last_raw),
    .o_end_c     (w_frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      ch_data      <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (w_raw_valid) begin
        for (int unsigned i = 0; i < NUM_CH; i++)
          if (r_ch == CW'(i)) r_shadow[i] <= last_raw[9:2];
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_SETUP;
            r_ch    <= '0;
            busy    <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_frame_end) begin
            if (w_last_ch) r_state <= S_DONE;
            else           r_ch    <= r_ch + CW'(1);
          end
        end
        S_DONE: begin
          for (int unsigned i = 0; i < NUM_CH; i++) ch_data[8*i +: 8] <= r_shadow[i];
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Scoreboard bench for mcp3008_scanner with a behavioural MCP3008 model.
module tb_mcp3008_scanner;

  localparam int unsigned CD   = 25;
  localparam int unsigned NCH  = 4;
  localparam longint      SCAN = longint'(NCH) * 38 * CD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             start = 1'b0;
  logic             spi_miso = 1'b0;
  logic             spi_mosi, spi_sclk, spi_cs_n, busy, sample_valid;
  logic [NCH*8-1:0] ch_data;
  logic [9:0]       last_raw;

  mcp3008_scanner #(.CLK_DIV(CD), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .spi_miso(spi_miso),
    .spi_mosi(spi_mosi), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .busy(busy),
    .sample_valid(sample_valid), .ch_data(ch_data), .last_raw(last_raw)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     valid_cnt = 0;
  longint cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  // ---------------- behavioural ADC ----------------
  logic [9:0] adc_val [NCH];
  int         rises = 0;
  logic [4:0] cmd = '0;
  logic [9:0] mv;
  int         frame_idx = 0;
  longint     cs_hi_cyc = 0;
  bit         have_hi = 0;
  bit         cs_low_seen = 0;

  always @(negedge spi_cs_n) begin
    rises = 0;
    cmd = '0;
    spi_miso = 1'($urandom);
    if (rst_n && have_hi) begin
      checks++;
      if (cyc - cs_hi_cyc < 2 * CD) begin
        errors++;
        $display("FAIL cs_gap actual=%0d required>=%0d", cyc - cs_hi_cyc, 2 * CD);
      end
    end
  end

  always @(posedge spi_sclk) if (!spi_cs_n) begin
    rises++;
    if (rises <= 5) cmd = {cmd[3:0], spi_mosi};
  end

  // Result bits B9..B0 are driven after falling edges following rises 7..16.
  always @(negedge spi_sclk) if (!spi_cs_n) begin
    if (rises >= 7 && rises <= 16) begin
      mv = adc_val[int'(cmd[2:0]) % NCH];
      spi_miso = mv[4'(16 - rises)];
    end else begin
      spi_miso = 1'($urandom);
    end
  end

  always @(posedge spi_cs_n) if (rst_n) begin
    checks++;
    if (rises != 17 || cmd[4:3] != 2'b11 || cmd[2:0] != 3'(frame_idx)) begin
      errors++;
      $display("FAIL frame actual rises=%0d cmd=%b required rises=17 cmd=11%03b",
               rises, cmd, 3'(frame_idx));
    end
    frame_idx = (frame_idx + 1) % NCH;
    cs_hi_cyc = cyc;
    have_hi = 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [NCH*8-1:0] data;
    logic [9:0]       raw;
    longint           vcyc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [NCH*8-1:0] prev_data;

  task automatic push_exp(input longint acc);
    exp_t e;
    for (int n = 0; n < NCH; n++) e.data[8*n +: 8] = 8'(adc_val[n] >> 2);
    e.raw  = adc_val[NCH-1];
    e.vcyc = acc + SCAN + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!spi_cs_n) cs_low_seen = 1;
    if (!rst_n) begin
      prev_data = ch_data;
    end else begin
      if (spi_cs_n && spi_sclk) begin
        errors++;
        $display("FAIL sclk_idle actual sclk=1 cs_n=1 required sclk=0 at cyc %0d", cyc);
      end
      if (ch_data !== prev_data) begin
        checks++;
        if (sample_valid !== 1'b1) begin
          errors++;
          $display("FAIL snapshot actual ch_data changed to %h without valid required stable", ch_data);
        end
      end
      prev_data = ch_data;
      if (sample_valid === 1'b1) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual valid at cyc %0d required none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checks += 3;
          if (ch_data !== mon_e.data) begin
            errors++;
            $display("FAIL ch_data actual=%h required=%h", ch_data, mon_e.data);
          end
          if (last_raw !== mon_e.raw) begin
            errors++;
            $display("FAIL last_raw actual=%h required=%h", last_raw, mon_e.raw);
          end
          if (cyc != mon_e.vcyc) begin
            errors++;
            $display("FAIL valid_time actual=%0d required=%0d", cyc, mon_e.vcyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_start(output longint acc);
    @(negedge clk);
    acc = cyc + 1;
    push_exp(acc);
    ena = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", longint'(busy), 1);
  endtask

  task automatic wait_valid(input int target);
    longint n = 0;
    while (valid_cnt < target && n < SCAN + 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_arrived", longint'(valid_cnt >= target), 1);
  endtask

  task automatic run_scan();
    longint a;
    int t;
    t = valid_cnt + 1;
    do_start(a);
    wait_valid(t);
    tick(2);
    chk("busy_idle", longint'(busy), 0);
  endtask

  task automatic randomize_adc();
    for (int n = 0; n < NCH; n++) adc_val[n] = 10'($urandom_range(0, 1023));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint a;
    int     t;
    longint n;
    for (int i = 0; i < NCH; i++) adc_val[i] = '0;
    tick(3);
    chk("rst_cs_n", longint'(spi_cs_n), 1);
    chk("rst_sclk", longint'(spi_sclk), 0);
    chk("rst_mosi", longint'(spi_mosi), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(sample_valid), 0);
    chk("rst_ch_data", longint'(ch_data), 0);
    chk("rst_last_raw", longint'(last_raw), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    adc_val = '{10'h3FF, 10'h155, 10'h0AA, 10'h001};
    run_scan();
    chk("ch0_full_scale", longint'(ch_data[7:0]), 'hFF);

    adc_val = '{10'h200, 10'h0FF, 10'h003, 10'h3FC};
    run_scan();
    chk("plan_bytes", longint'(ch_data), 'hFF003F80);
    chk("plan_last_raw", longint'(last_raw), 'h3FC);

    adc_val = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
    t = valid_cnt + 1;
    do_start(a);
    tick(int'(SCAN) - 100);
    chk("snapshot_hold", longint'(ch_data), 'hFF003F80);
    wait_valid(t);
    chk("snapshot_new", longint'(ch_data), 'hAA5500FF);

    repeat (3) begin
      randomize_adc();
      run_scan();
    end

    randomize_adc();
    t = valid_cnt;
    do_start(a);
    tick(1000);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1500);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    wait_valid(t + 1);
    tick(200);
    chk("single_valid", longint'(valid_cnt), longint'(t + 1));

    ena = 1'b0;
    cs_low_seen = 0;
    t = valid_cnt;
    start = 1'b1;
    tick(200);
    start = 1'b0;
    chk("ena0_cs_high", longint'(cs_low_seen), 0);
    chk("ena0_busy", longint'(busy), 0);
    chk("ena0_no_valid", longint'(valid_cnt), longint'(t));

    randomize_adc();
    t = valid_cnt + 1;
    do_start(a);
    tick(500);
    ena = 1'b0;
    wait_valid(t);

    randomize_adc();
    do_start(a);
    n = 0;
    while (!(rises == 10 && !spi_cs_n) && n < SCAN) begin
      @(negedge clk);
      n++;
    end
    chk("reach_edge10", longint'(rises), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", longint'(spi_cs_n), 1);
    chk("mid_rst_sclk", longint'(spi_sclk), 0);
    chk("mid_rst_mosi", longint'(spi_mosi), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_valid", longint'(sample_valid), 0);
    chk("mid_rst_ch_data", longint'(ch_data), 0);
    chk("mid_rst_last_raw", longint'(last_raw), 0);
    exp_q.delete();
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    frame_idx = 0;
    tick(2);
    randomize_adc();
    run_scan();

    randomize_adc();
    @(negedge clk);
    a = cyc + 1;
    push_exp(a);
    push_exp(a + SCAN + 2);
    push_exp(a + 2 * (SCAN + 2));
    t = valid_cnt;
    ena = 1'b1;
    start = 1'b1;
    while (cyc < a + 2 * (SCAN + 2) + 5) @(negedge clk);
    start = 1'b0;
    wait_valid(t + 3);
    tick(5);
    chk("no_retrigger", longint'(busy), 0);
    tick(20);
    chk("queue_empty", longint'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcp3008_scanner.md
Name: mcp3008_scanner

Overview:
- SPI master that drives the external MCP3008 ADC and scans single-ended channels 0..NUM_CH-1 in order.
- Each 10-bit result is scaled to 8 bits and all channels are published together as one snapshot.
- Feeds the sensor registers (height, green, density, temp) of the microgreen classifier top.
- Replaces the tied-off SPI outputs on uio[0..2]; MISO arrives on ui_in[0].

Parameters:
- CLK_DIV, 25: SCLK half-period in clk cycles (1 MHz SCLK at 50 MHz). Legal range 2..255.
- NUM_CH, 4: channels per scan. Legal range 1..8.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; a scan may only start while high
- start  in  1  scan request, level-sampled
- spi_miso  in  1  ADC DOUT
- spi_mosi  out  1  ADC DIN
- spi_sclk  out  1  ADC CLK, SPI mode 0, idles low
- spi_cs_n  out  1  ADC chip select, active low
- busy  out  1  high from start acceptance until sample_valid
- sample_valid  out  1  one-cycle pulse when ch_data updates
- ch_data  out  NUM_CH*8  channel n in bits [8n+7:8n], value = raw10[9:2]
- last_raw  out  10  unscaled result of the most recent frame

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-frame:
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0.
  - busy=0, sample_valid=0, ch_data=0, last_raw=0.
  - FSM returns to IDLE.
- Start acceptance:
  - start is accepted on a clk edge only when the FSM is in IDLE and ena=1 and start=1.
  - start while busy is ignored, not queued.
  - Once accepted, a scan completes even if ena drops.
- States:
  - IDLE: waits for an accepted start; sets ch=0, busy=1, goes to SETUP.
  - SETUP: spi_cs_n=0, spi_mosi=cmd bit 0; lasts CLK_DIV cycles.
  - SHIFT: 17 SCLK periods, each CLK_DIV low then CLK_DIV high. Rising edges are numbered 1..17.
  - HOLD: SCLK low for CLK_DIV cycles, then spi_cs_n=1.
  - GAP: CS stays high for 2*CLK_DIV cycles.
  - Channel step at end of GAP: if ch<NUM_CH-1, ch increments and the FSM returns to SETUP; otherwise it goes to DONE.
  - DONE: one cycle; ch_data is loaded from the shadow registers, sample_valid=1, busy=0, then IDLE.
- Command sequence on spi_mosi:
  - Bits are 1 (start), 1 (SGL), D2, D1, D0 = ch, MSB first.
  - Bit k is presented before rising edge k+1; updates occur only on SCLK falling transitions (and SETUP entry).
  - After bit 4, spi_mosi=0.
- MISO capture:
  - MISO is sampled in the clk cycle in which SCLK rises, on rising edges 8..17, giving B9..B0.
  - Rising edges 6 (sample window) and 7 (null bit) are ignored.
- Result storage:
  - At HOLD entry: last_raw is loaded with raw10, and shadow[ch] with raw10[9:2] (truncation, no rounding).
  - ch_data does not change before DONE, so consumers always see a coherent snapshot.
- Timing:
  - One channel frame plus gap = 38*CLK_DIV cycles.
  - sample_valid rises exactly NUM_CH*38*CLK_DIV + 1 cycles after the accepting edge.
  - Default: 3801 cycles, about 76 µs.
- Back-to-back scans: start held high re-triggers on the cycle after DONE, since IDLE accepts immediately.
- Internal counters:
  - Divider counter: 8 bits.
  - SCLK edge counter: 5 bits.
  - Channel index: 3 bits.
  - No counter may wrap inside a frame.

Decomposition:
- Shared package mcp_pkg holds:
  - the FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP, DONE);
  - MCP_FRAME_EDGES=17;
  - MCP_FIRST_DATA_EDGE=8;
  - MCP_CMD_BITS=5;
  - MCP_FRAME_HALFPERIODS=38.
- One natural sub-module, mcp_spi_frame:
  - performs a single 17-clock transaction for a given channel;
  - returns raw10 with a done pulse.
- The scanner wraps mcp_spi_frame with channel sequencing and shadow/snapshot registers.

Test Plan:
- Single-channel frame: reset, ADC model returns 0x3FF on ch0, pulse start with NUM_CH=1, CLK_DIV=2 -> MOSI bits 1,1,0,0,0; exactly 17 SCLK rises; last_raw=0x3FF; ch_data=0xFF; sample_valid at cycle 77.
- Full scan with defaults: model returns ch0=0x200, ch1=0x0FF, ch2=0x003, ch3=0x3FC -> ch_data bytes 0x80, 0x3F, 0x00, 0xFF; D2..D0 sequence 0,1,2,3; CS high ≥50 cycles between frames; valid at +3801.
- Snapshot coherence: second scan with different model values -> ch_data unchanged until the DONE cycle, then all bytes change in the same cycle.
- Start gating: start pulsed mid-scan -> ignored, exactly one sample_valid. start with ena=0 -> CS stays high. ena dropped mid-scan -> scan still completes.
- Reset mid-frame: assert rst_n low during SHIFT edge 10 -> CS high, SCLK low, outputs zero in the same cycle; after release, a fresh start gives a correct full frame.
- Continuous start=1 -> sample_valid pulses every 3802 cycles; SCLK is never high while CS is high.
